lsu_byte_sequencer: RTL

//  Load/store sequencer between the RV32I core's memory stage and a byte-wide

---
 rtl/lsu_byte_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lsu_byte_sequencer.sv
// Load/store sequencer: breaks RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into byte-wide
// RAM accesses and returns one extended response per request.
module lsu_byte_sequencer #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [AW-1:0]     req_addr,
  input  logic [DW-1:0]     req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DW-1:0]     rsp_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int NUM_LANES = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]                      state_q, state_d;
  logic [2:0]                      cnt_q, cnt_d;
  logic                            write_q, write_d;
  logic [2:0]                      f3_q, f3_d;
  logic [MEM_AW-1:0]               base_q, base_d;
  logic [DW-1:0]                   wdata_q, wdata_d;
  logic [NUM_LANES-1:0][7:0]       lanes_q, lanes_d;
  logic                            rsp_err_q, rsp_err_d;
  logic [DW-1:0]                   rsp_rdata_q, rsp_rdata_d;

  logic       req_err;
  logic [2:0] last_cnt;
  logic [1:0] cap_lane;

  // Any of these faults is answered immediately without touching the RAM.
  always_comb begin
    req_err = 1'b0;
    if (req_funct3[1:0] == 2'd1 && req_addr[0])          req_err = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0) req_err = 1'b1;
    if (req_addr[AW-1:MEM_AW] != '0)                      req_err = 1'b1;
    if (req_write && req_funct3 > 3'd2)                   req_err = 1'b1;
    if (!req_write && (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7))
      req_err = 1'b1;
  end

  always_comb begin
    case (f3_q[1:0])
      2'd0:    last_cnt = 3'd0;
      2'd1:    last_cnt = 3'd1;
      default: last_cnt = 3'd3;
    endcase
  end

  // Read data lags the strobe by one cycle, so it belongs to the previous count.
  assign cap_lane = cnt_q[1:0] - 2'd1;

  function automatic logic [31:0] extend(input logic [NUM_LANES-1:0][7:0] l,
                                         input logic [2:0] f3);
    logic s;
    s = ~f3[2];
    case (f3[1:0])
      2'd0:    extend = {{24{s & l[0][7]}}, l[0]};
      2'd1:    extend = {{16{s & l[1][7]}}, l[1], l[0]};
      default: extend = l;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    f3_d        = f3_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    lanes_d     = lanes_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          f3_d    = req_funct3;
          base_d  = req_addr[MEM_AW-1:0];
          wdata_d = req_wdata;
          cnt_d   = 3'd0;
          lanes_d = '0;
          if (req_err) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = S_RESP;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (!write_q && cnt_q != 3'd0) lanes_d[cap_lane] = mem_rdata;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == last_cnt) begin
          if (write_q) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
            state_d     = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        lanes_d[cap_lane] = mem_rdata;
        cnt_d             = cnt_q + 3'd1;
        rsp_err_d         = 1'b0;
        rsp_rdata_d       = extend(lanes_d, f3_q);
        state_d           = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      f3_q        <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      lanes_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      f3_q        <= f3_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      lanes_q     <= lanes_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_read  = (state_q == S_ACCESS) && !write_q;
  assign mem_write = (state_q == S_ACCESS) && write_q;
  assign mem_addr  = (state_q == S_ACCESS) ? base_q + MEM_AW'(cnt_q) : '0;
  assign mem_wdata = mem_write ? wdata_q[8*cnt_q[1:0] +: 8] : 8'h00;

endmodule
